// File: rtl/cpu_commit_tracer_if.sv
// Commit-stream and trace-stream signals between the CPU/bench and the commit tracer.
// The tracer uses the slave side. The environment uses the master side: it drives commits and trace_ready.
interface cpu_commit_tracer_if #(
    parameter int SEQ_W = 16
);
    logic                commit_valid;
    logic [31:0]         commit_pc;
    logic [31:0]         commit_instr;
    logic                commit_we;
    logic [4:0]          commit_rd;
    logic [31:0]         commit_wdata;
    logic                trace_valid;
    logic                trace_ready;
    logic [SEQ_W+101:0]  trace_data;

    modport master (
        output commit_valid, commit_pc, commit_instr, commit_we, commit_rd, commit_wdata,
        output trace_ready,
        input  trace_valid, trace_data
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr, commit_we, commit_rd, commit_wdata,
        input  trace_ready,
        output trace_valid, trace_data
    );
endinterface

// File: rtl/cpu_commit_tracer.sv
// Captures retired-instruction records into a show-ahead FIFO and streams them out.
// It stops accepting commits at the halt opcode and raises done once the FIFO has drained.
module cpu_commit_tracer #(
    parameter int          DEPTH   = 16,
    parameter logic [5:0]  HALT_OP = 6'h3F,
    parameter int          SEQ_W   = 16
) (
    input  logic                       CLK,
    input  logic                       Reset,
    cpu_commit_tracer_if.slave         bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic                       halted,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = SEQ_W + 102;

    // state | meaning
    // RUN   | accepting commits
    // DRAIN | halt seen, commits ignored, waiting for FIFO to empty
    // DONE  | FIFO drained after halt, terminal until Reset
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [RW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [SEQ_W-1:0]   seq;

    logic               push_req;
    logic               pop;
    logic               accept;
    logic               drop;
    logic               is_halt;
    logic [LW-1:0]      level_next;

    assign push_req   = bus.commit_valid && (state == RUN);
    assign pop        = bus.trace_valid && bus.trace_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept     = push_req && ((level != LW'(DEPTH)) || pop);
    assign drop       = push_req && !accept;
    assign is_halt    = (bus.commit_instr[31:26] == HALT_OP);
    assign level_next = level + LW'(accept) - LW'(pop);

    assign bus.trace_valid = (level != '0);
    assign bus.trace_data  = bus.trace_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wr_ptr] <= {seq, bus.commit_pc, bus.commit_instr, bus.commit_we,
                            bus.commit_rd, bus.commit_wdata};
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'h00;
            halted     <= 1'b0;
            done       <= 1'b0;
        end else begin
            level <= level_next;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            // Dropped commits still consume a sequence number so gaps are visible downstream.
            if (push_req) seq <= seq + SEQ_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end

            case (state)
                RUN: begin
                    if (push_req && is_halt) begin
                        state  <= DRAIN;
                        halted <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (level_next == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_commit_tracer.sv
// Directed bench for cpu_commit_tracer: a vector table for basic streaming,
// plus hand-written sequences for overflow, halt/drain, async reset and sequence wrap.
module tb_cpu_commit_tracer;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    cpu_commit_tracer_if #(.SEQ_W(16)) b  ();
    cpu_commit_tracer_if #(.SEQ_W(4))  b2 ();

    logic [4:0] level, level2;
    logic       overflow, overflow2, halted, halted2, done, done2;
    logic [7:0] drop_count, drop_count2;

    cpu_commit_tracer #(.DEPTH(16), .HALT_OP(6'h3F), .SEQ_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .bus(b), .level(level), .overflow(overflow),
        .drop_count(drop_count), .halted(halted), .done(done));

    cpu_commit_tracer #(.DEPTH(16), .HALT_OP(6'h3F), .SEQ_W(4)) dut2 (
        .CLK(CLK), .Reset(Reset), .bus(b2), .level(level2), .overflow(overflow2),
        .drop_count(drop_count2), .halted(halted2), .done(done2));

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic        cv;
        logic [31:0] pc;
        logic        rdy;
        logic        exp_valid;
        logic [4:0]  exp_level;
        logic [15:0] exp_seq;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [117:0] mk(input int s, input logic [31:0] pc, input logic [31:0] instr);
        logic [15:0] s16;
        s16 = s[15:0];
        return {s16, pc, instr, 1'b1, pc[6:2], pc ^ 32'hA5A5_0000};
    endfunction

    task automatic drive(input logic cv, input logic [31:0] pc, input logic [31:0] instr);
        b.commit_valid = cv;
        b.commit_pc    = pc;
        b.commit_instr = instr;
        b.commit_we    = 1'b1;
        b.commit_rd    = pc[6:2];
        b.commit_wdata = pc ^ 32'hA5A5_0000;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, NOP);
        b.trace_ready = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
    endtask

    logic [117:0] exp_head;
    int exp_lvl;
    int pops;
    logic rdy;

    initial begin
        drive(1'b0, 32'h0, NOP);
        b.trace_ready = 1'b0;
        b2.commit_valid = 1'b0; b2.commit_pc = '0; b2.commit_instr = NOP;
        b2.commit_we = 1'b0; b2.commit_rd = '0; b2.commit_wdata = '0; b2.trace_ready = 1'b1;

        #3;
        chk("reset_valid", 128'(b.trace_valid), 128'(0));
        chk("reset_data",  128'(b.trace_data),  128'(0));
        chk("reset_level", 128'(level), 128'(0));
        chk("reset_flags", 128'({overflow, drop_count, halted, done}), 128'(0));
        @(negedge CLK);
        Reset = 1'b0;

        // ---- test 1: basic streaming via vector table ----
        //          cv    pc          rdy   valid lvl  seq   head pc
        vecs[0] = '{1'b1, 32'h00, 1'b1, 1'b1, 5'd1, 16'd0, 32'h00};
        vecs[1] = '{1'b1, 32'h04, 1'b1, 1'b1, 5'd1, 16'd1, 32'h04};
        vecs[2] = '{1'b1, 32'h08, 1'b1, 1'b1, 5'd1, 16'd2, 32'h08};
        vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 5'd0, 16'd0, 32'h00};
        vecs[4] = '{1'b1, 32'h0C, 1'b0, 1'b1, 5'd1, 16'd3, 32'h0C};
        vecs[5] = '{1'b1, 32'h10, 1'b0, 1'b1, 5'd2, 16'd3, 32'h0C};
        vecs[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 5'd1, 16'd4, 32'h10};
        vecs[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 5'd0, 16'd0, 32'h00};
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].cv, vecs[i].pc, NOP);
            b.trace_ready = vecs[i].rdy;
            tick();
            chk($sformatf("t1_valid[%0d]", i), 128'(b.trace_valid), 128'(vecs[i].exp_valid));
            chk($sformatf("t1_level[%0d]", i), 128'(level), 128'(vecs[i].exp_level));
            exp_head = vecs[i].exp_valid ? mk(int'(vecs[i].exp_seq), vecs[i].exp_pc, NOP) : '0;
            chk($sformatf("t1_data[%0d]", i), 128'(b.trace_data), 128'(exp_head));
        end

        // ---- test 2: overflow with ready low, then drain ----
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(4 * i), NOP);
            tick();
            chk($sformatf("t2_fill_level[%0d]", i), 128'(level), 128'((i + 1 > 16) ? 16 : i + 1));
            chk($sformatf("t2_hold[%0d]", i), 128'(b.trace_data), 128'(mk(0, 32'h0, NOP)));
        end
        drive(1'b0, 32'h0, NOP);
        chk("t2_overflow", 128'(overflow), 128'(1));
        chk("t2_drops", 128'(drop_count), 128'(4));
        b.trace_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t2_drain[%0d]", k), 128'(b.trace_data), 128'(mk(k, 32'(4 * k), NOP)));
            tick();
        end
        chk("t2_empty", 128'(level), 128'(0));
        drive(1'b1, 32'h100, NOP);
        tick();
        drive(1'b0, 32'h0, NOP);
        chk("t2_seq20", 128'(b.trace_data), 128'(mk(20, 32'h100, NOP)));
        tick();

        // ---- test 3: full FIFO, push and pop in the same cycle ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(4 * i), NOP);
            tick();
        end
        chk("t3_full", 128'(level), 128'(16));
        b.trace_ready = 1'b1;
        drive(1'b1, 32'h40, NOP);
        tick();
        chk("t3_pp_level", 128'(level), 128'(16));
        chk("t3_pp_flags", 128'({overflow, drop_count}), 128'(0));
        chk("t3_pp_head", 128'(b.trace_data), 128'(mk(1, 32'h4, NOP)));
        b.trace_ready = 1'b0;
        tick();
        chk("t3_drop1", 128'({overflow, drop_count}), 128'({1'b1, 8'd1}));
        b.trace_ready = 1'b1;
        tick();
        chk("t3_pp2_level", 128'(level), 128'(16));
        chk("t3_pp2_flags", 128'({overflow, drop_count}), 128'({1'b1, 8'd1}));
        b.trace_ready = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        chk("t3_saturate", 128'(drop_count), 128'(8'hFF));
        drive(1'b0, 32'h0, NOP);

        // ---- test 4: halt with 5 queued, ready toggling ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(4 * i), NOP);
            tick();
        end
        drive(1'b1, 32'h14, HALT);
        tick();
        chk("t4_halted", 128'(halted), 128'(1));
        chk("t4_done0", 128'(done), 128'(0));
        chk("t4_level6", 128'(level), 128'(6));
        exp_lvl = 6;
        pops = 0;
        for (int cyc = 0; cyc < 40 && pops < 6; cyc++) begin
            rdy = (cyc % 2 == 0);
            b.trace_ready = rdy;
            drive(1'b1, 32'(32'h200 + 4 * cyc), NOP);
            exp_head = (pops < 5) ? mk(pops, 32'(4 * pops), NOP) : mk(5, 32'h14, HALT);
            chk($sformatf("t4_head[%0d]", cyc), 128'(b.trace_data), 128'(exp_head));
            tick();
            if (rdy && exp_lvl > 0) begin
                pops++;
                exp_lvl--;
            end
            chk($sformatf("t4_level[%0d]", cyc), 128'(level), 128'(exp_lvl));
            chk($sformatf("t4_done[%0d]", cyc), 128'(done), 128'(pops == 6));
        end
        chk("t4_pops", 128'(pops), 128'(6));
        tick();
        tick();
        chk("t4_ignored", 128'({level, overflow, drop_count}), 128'(0));
        chk("t4_sticky", 128'({halted, done}), 128'(2'b11));
        drive(1'b0, 32'h0, NOP);

        // ---- test 5: async reset mid-drain ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(4 * i), NOP);
            tick();
        end
        drive(1'b1, 32'h18, HALT);
        tick();
        drive(1'b0, 32'h0, NOP);
        chk("t5_level7", 128'(level), 128'(7));
        chk("t5_halted", 128'(halted), 128'(1));
        #3;
        Reset = 1'b1;
        #1;
        chk("t5_rst_valid", 128'(b.trace_valid), 128'(0));
        chk("t5_rst_data",  128'(b.trace_data),  128'(0));
        chk("t5_rst_level", 128'(level), 128'(0));
        chk("t5_rst_flags", 128'({overflow, drop_count, halted, done}), 128'(0));
        #1;
        Reset = 1'b0;
        drive(1'b1, 32'h300, NOP);
        tick();
        drive(1'b0, 32'h0, NOP);
        chk("t5_seq_restart", 128'(b.trace_data), 128'(mk(0, 32'h300, NOP)));

        // ---- test 6: sequence wrap at SEQ_W=4 ----
        b2.trace_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b2.commit_valid = 1'b1;
            b2.commit_pc    = 32'(4 * i);
            b2.commit_instr = NOP;
            tick();
            chk($sformatf("t6_valid[%0d]", i), 128'(b2.trace_valid), 128'(1));
            chk($sformatf("t6_seq[%0d]", i), 128'(b2.trace_data[105:102]), 128'(i % 16));
            chk($sformatf("t6_pc[%0d]", i), 128'(b2.trace_data[101:70]), 128'(4 * i));
        end
        b2.commit_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
